// File: rtl/prng_rate_ctrl_pkg.sv
// Shared types and default widths for the PRNG rate controller.
// Optional burst support is selected with the PRNG_RATE_BURST_EN macro.
package prng_rate_pkg;

   localparam int unsigned SIZE_DEF    = 12;
   localparam int unsigned BURST_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/prng_rate_ctrl_if.sv
// Config/control/status bundle between the FIR sequencer and the PRNG rate controller.
// cfg_burst is only consumed when PRNG_RATE_BURST_EN is defined.
interface prng_rate_ctrl_if
   import prng_rate_pkg::*;
#(
   parameter int unsigned SIZE    = SIZE_DEF,
   parameter int unsigned BURST_W = BURST_W_DEF
) ();

   logic               cfg_valid;
   logic               cfg_ready;
   logic [SIZE-1:0]    cfg_div;
   logic [BURST_W-1:0] cfg_burst;
   logic               start;
   logic               stop;
   logic               prng_en;
   logic               busy;
   logic               done;
   logic [BURST_W-1:0] tick_cnt;

   modport master (
      output cfg_valid, cfg_div, cfg_burst, start, stop,
      input  cfg_ready, prng_en, busy, done, tick_cnt
   );

   modport slave (
      input  cfg_valid, cfg_div, cfg_burst, start, stop,
      output cfg_ready, prng_en, busy, done, tick_cnt
   );

endinterface

// File: rtl/prng_rate_ctrl_div_counter.sv
// Frequency-divider up-counter: loads an init value, increments, and flags all-ones.
// The carry is a pure decode of the register, so it has no input-to-output path.
module prng_div_counter
   import prng_rate_pkg::*;
#(
   parameter int unsigned SIZE = SIZE_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            inc_i,
   input  logic [SIZE-1:0] init_i,
   output logic            carry_o
);

   logic [SIZE-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = init_i;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '1;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign carry_o = &cnt_q;

endmodule

// File: rtl/prng_rate_ctrl.sv
// PRNG rate controller: FSM, config shadow registers and tick counter around the divider.
// Define PRNG_RATE_BURST_EN for fixed-length bursts with a done pulse; otherwise runs are continuous.
module prng_rate_ctrl
   import prng_rate_pkg::*;
#(
   parameter int unsigned SIZE    = SIZE_DEF,
   parameter int unsigned BURST_W = BURST_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   prng_rate_ctrl_if.slave ctrl
);

   state_e             state_q, state_d;
   logic [SIZE-1:0]    div_q, div_d;
   logic [BURST_W-1:0] tick_q, tick_d;
   logic [SIZE-1:0]    cnt_init;
   logic               cnt_load, cnt_inc, carry;
`ifdef PRNG_RATE_BURST_EN
   logic [BURST_W-1:0] burst_q, burst_d;
`else
   logic               unused_burst;
   assign unused_burst = ^ctrl.cfg_burst;
`endif

   prng_div_counter #(.SIZE(SIZE)) u_div (
      .clk     (clk),
      .rst_n   (rst),
      .load_i  (cnt_load),
      .inc_i   (cnt_inc),
      .init_i  (cnt_init),
      .carry_o (carry)
   );

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      tick_d   = tick_q;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      cnt_init = ~div_q;
`ifdef PRNG_RATE_BURST_EN
      burst_d  = burst_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (ctrl.cfg_valid) begin
               div_d = ctrl.cfg_div;
`ifdef PRNG_RATE_BURST_EN
               burst_d = ctrl.cfg_burst;
`endif
            end
            // Init taken from div_d so a same-cycle handshake governs this run.
            if (ctrl.start) begin
               cnt_load = 1'b1;
               cnt_init = ~div_d;
               tick_d   = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            cnt_load = carry;
            cnt_inc  = !carry;
            if (carry) begin
               tick_d = tick_q + 1'b1;
            end
            if (ctrl.stop) begin
               state_d = IDLE;
            end
`ifdef PRNG_RATE_BURST_EN
            else if (carry && (burst_q != '0) && (tick_q == burst_q - 1'b1)) begin
               state_d = DONE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         tick_q  <= '0;
`ifdef PRNG_RATE_BURST_EN
         burst_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
`ifdef PRNG_RATE_BURST_EN
         burst_q <= burst_d;
`endif
      end
   end

   assign ctrl.cfg_ready = (state_q == IDLE);
   assign ctrl.busy      = (state_q != IDLE);
   assign ctrl.prng_en   = (state_q == RUN) && carry;
   assign ctrl.tick_cnt  = tick_q;
`ifdef PRNG_RATE_BURST_EN
   assign ctrl.done      = (state_q == DONE);
`else
   assign ctrl.done      = 1'b0;
`endif

endmodule

// File: tb/tb_prng_rate_ctrl.sv
// Self-checking bench for prng_rate_ctrl against a cycle-index reference model.
// Expectations follow PRNG_RATE_BURST_EN when it is defined for the build.
module tb_prng_rate_ctrl;

`ifdef PRNG_RATE_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   prng_rate_ctrl_if #(.SIZE(12), .BURST_W(8)) bus ();

   prng_rate_ctrl #(.SIZE(12), .BURST_W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .ctrl (bus)
   );

   always #5 clk = ~clk;

   // Reference model: run position k (1 = first RUN cycle); a tick falls where k is a multiple
   // of D+1, and a burst ends on the tick at k == B*(D+1).
   logic        m_run, m_done;
   int          m_k;
   logic [11:0] m_div;
   logic [7:0]  m_burst, m_ticks;
   logic        m_en;

   assign m_en = m_run && ((m_k % (int'(m_div) + 1)) == 0);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_run   <= 1'b0;
         m_done  <= 1'b0;
         m_k     <= 0;
         m_div   <= '0;
         m_burst <= '0;
         m_ticks <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_run) begin
         if (m_en) m_ticks <= m_ticks + 8'd1;
         if (bus.stop) begin
            m_run <= 1'b0;
         end else if (BURST_EN && m_burst != 0 && m_en &&
                      m_k == int'(m_burst) * (int'(m_div) + 1)) begin
            m_run  <= 1'b0;
            m_done <= 1'b1;
         end
         m_k <= m_k + 1;
      end else begin
         if (bus.cfg_valid) begin
            m_div   <= bus.cfg_div;
            m_burst <= bus.cfg_burst;
         end
         if (bus.start) begin
            m_run   <= 1'b1;
            m_k     <= 1;
            m_ticks <= '0;
         end
      end
   end

   function automatic logic [11:0] dut_vec();
      return {bus.prng_en, bus.busy, bus.done, bus.cfg_ready, bus.tick_cnt};
   endfunction

   function automatic logic [11:0] exp_vec();
      return {m_en, m_run | m_done, m_done, !(m_run | m_done), m_ticks};
   endfunction

   task automatic drive(input logic v, input logic [11:0] d, input logic [7:0] b,
                        input logic s, input logic p);
      bus.cfg_valid = v;
      bus.cfg_div   = d;
      bus.cfg_burst = b;
      bus.start     = s;
      bus.stop      = p;
   endtask

   task automatic settle();
      @(negedge clk); drive(0, 0, 0, 0, 1);
      @(negedge clk); drive(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (dut_vec() !== 12'b0001_0000_0000) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", dut_vec(), 12'b0001_0000_0000);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_burst();
      logic en_c;
      drive(1, 12'd3, 8'd4, 1, 0);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL burst_vec cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         en_c = (c % 4 == 0) && (!BURST_EN || c <= 16);
         checks++;
         if (bus.prng_en !== en_c) begin
            errors++;
            $display("FAIL burst_tick cyc=%0d got=%b exp=%b", c, bus.prng_en, en_c);
         end
         if (c == 17) begin
            checks++;
            if (bus.done !== BURST_EN) begin
               errors++;
               $display("FAIL burst_done got=%b exp=%b", bus.done, BURST_EN);
            end
`ifdef PRNG_RATE_BURST_EN
            checks++;
            if (bus.tick_cnt !== 8'd4) begin
               errors++;
               $display("FAIL burst_count got=%0d exp=4", bus.tick_cnt);
            end
`endif
         end
         if (c == 18) begin
            checks++;
            if (bus.busy !== !BURST_EN) begin
               errors++;
               $display("FAIL burst_idle got=%b exp=%b", bus.busy, !BURST_EN);
            end
         end
      end
      settle();
   endtask

   task automatic test_continuous();
      drive(1, 12'd0, 8'd0, 1, 0);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL cont_vec cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (c <= 10) begin
            checks++;
            if (bus.prng_en !== 1'b1) begin
               errors++;
               $display("FAIL cont_tick cyc=%0d got=%b exp=1", c, bus.prng_en);
            end
         end else begin
            checks++;
            if ({bus.busy, bus.done, bus.tick_cnt} !== {1'b0, 1'b0, 8'd10}) begin
               errors++;
               $display("FAIL cont_end got=%b/%b/%0d exp=0/0/10", bus.busy, bus.done, bus.tick_cnt);
            end
         end
         drive(0, 0, 0, 0, c == 10);
      end
      settle();
   endtask

   task automatic test_stop_final();
      drive(1, 12'd1, 8'd2, 1, 0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stopfin_vec cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (c == 4) begin
            checks++;
            if (bus.prng_en !== 1'b1) begin
               errors++;
               $display("FAIL stopfin_tick got=%b exp=1", bus.prng_en);
            end
         end
         if (c >= 5) begin
            checks++;
            if ({bus.busy, bus.done, bus.tick_cnt} !== {1'b0, 1'b0, 8'd2}) begin
               errors++;
               $display("FAIL stopfin_end cyc=%0d got=%b/%b/%0d exp=0/0/2", c, bus.busy, bus.done, bus.tick_cnt);
            end
         end
         drive(0, 0, 0, 0, c == 4);
      end
      settle();
   endtask

   task automatic test_cfg_in_run();
      drive(1, 12'd2, 8'd0, 1, 0);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL cfgrun_vec cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         if (c == 3) begin
            checks++;
            if (bus.cfg_ready !== 1'b0) begin
               errors++;
               $display("FAIL cfgrun_ready got=%b exp=0", bus.cfg_ready);
            end
         end
         drive(c == 3, 12'd7, 8'd0, 0, c == 8);
      end
      repeat (2) @(negedge clk);
      drive(0, 0, 0, 1, 0);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0);
         checks++;
         if (bus.prng_en !== (c % 3 == 0)) begin
            errors++;
            $display("FAIL cfgrun_olddiv cyc=%0d got=%b exp=%b", c, bus.prng_en, c % 3 == 0);
         end
      end
      settle();
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 0, 1, 0);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rstmid_vec cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({bus.prng_en, bus.busy, bus.tick_cnt, bus.cfg_ready} !== {1'b0, 1'b0, 8'd0, 1'b1}) begin
         errors++;
         $display("FAIL rstmid_async got=%b/%b/%0d/%b exp=0/0/0/1", bus.prng_en, bus.busy, bus.tick_cnt, bus.cfg_ready);
      end
      drive(1, 12'd5, 8'd9, 1, 0);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 1, 0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0);
         checks++;
         if (bus.prng_en !== 1'b1 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rstmid_after cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
      end
      settle();
   endtask

   task automatic test_wrap();
      drive(1, 12'd0, 8'd3, 1, 0);
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL wrap_vec cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
`ifndef PRNG_RATE_BURST_EN
         if (c == 256 || c == 257) begin
            checks++;
            if (bus.tick_cnt !== ((c == 256) ? 8'd255 : 8'd0) || bus.done !== 1'b0) begin
               errors++;
               $display("FAIL wrap_count cyc=%0d got=%0d done=%b", c, bus.tick_cnt, bus.done);
            end
         end
`else
         if (c == 5) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.tick_cnt !== 8'd3) begin
               errors++;
               $display("FAIL wrap_burst got=%b/%0d exp=0/3", bus.busy, bus.tick_cnt);
            end
         end
`endif
      end
      settle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random_vec cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
         end
         drive(1'($urandom_range(1)), 12'($urandom_range(5)), 8'($urandom_range(4)),
               $urandom_range(3) == 0, $urandom_range(15) == 0);
      end
      settle();
   endtask

   initial begin
      drive(0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      test_reset();
      test_burst();
      test_continuous();
      test_stop_final();
      test_cfg_in_run();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prng_rate_ctrl.md
# prng_rate_ctrl

Rate controller for the PRNG stage of the FIR filter datapath. It owns the frequency-divider counter, accepts a programmable division ratio and burst length over a valid/ready config port, and issues single-cycle `prng_en` ticks to the PRNG. It runs either continuously or for a fixed number of ticks, then reports completion.

## Interface
- `SIZE`, 12: divider counter width.
- `BURST_W`, 8: burst-length and tick-counter width.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  config word offered.
- `cfg_ready`  out  1  config accepted when `cfg_valid & cfg_ready`.
- `cfg_div`  in  SIZE  tick period minus one (D); period = D+1 cycles.
- `cfg_burst`  in  BURST_W  ticks per run (B); 0 = continuous.
- `start`  in  1  begin a run (honoured in IDLE only).
- `stop`  in  1  abort a run (honoured in RUN only).
- `prng_en`  out  1  one-cycle PRNG step enable.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse on burst completion.
- `tick_cnt`  out  BURST_W  ticks issued in current/last run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `cfg_ready`=1. A handshake stores `cfg_div`→`div_q`, `cfg_burst`→`burst_q`. Handshake and `start` in the same cycle: the run uses the new values.
- IDLE + `start`: counter ← init = ~D (bitwise), `tick_cnt` ← 0, → RUN.
- RUN: counter increments each cycle. When counter is all ones (carry), `prng_en`=1 that cycle and counter reloads init at the next edge. Ticks are therefore exactly D+1 cycles apart. D=0 gives a tick every cycle.
- Each tick increments `tick_cnt`. In continuous mode it wraps modulo 2^BURST_W.
- Burst mode (B≠0): the tick where `tick_cnt`==B-1 → DONE. `tick_cnt` ends at B and holds until the next `start`.
- DONE: `done`=1 for one cycle, → IDLE.
- `stop` in RUN → IDLE at the next edge, with no `done`. If `stop` coincides with the final tick, the tick is still emitted and `stop` wins (no `done`).
- `start` outside IDLE and `stop` outside RUN are ignored. `cfg_ready`=0 outside IDLE.
- Reset (any time, including mid-run): state IDLE, counter ← all ones, `div_q`=0, `burst_q`=0, `tick_cnt`=0, `prng_en`=0, `done`=0, `busy`=0, `cfg_ready`=1. Config handshakes while `rst`=0 have no effect.

## Timing
- `prng_en`, `busy`, `done`, `cfg_ready` are decoded from registered state/counter only, so there are no input-to-output combinational paths.
- Start accepted at edge E0: first RUN cycle is E0+1. First tick is in cycle E0+D+1, then every D+1 cycles.
- Burst of B: last tick at cycle E0+B·(D+1), `done` in the next cycle, IDLE (`cfg_ready`=1) one cycle later.
- Back-to-back runs: `start` can be accepted in the first IDLE cycle after DONE.

## Configuration
- `PRNG_RATE_BURST_EN` defined: burst logic present as described.
- Macro undefined: `burst_q` and the burst compare are removed and `cfg_burst` is ignored. Every run is continuous until `stop`, `done` is tied to 0, and the DONE state is unreachable/omitted. `tick_cnt` still counts and wraps.

## Structure
- Package `prng_rate_pkg`: state enum (IDLE, RUN, DONE) and its encoding, plus default `SIZE`/`BURST_W` constants.
- Sub-module `prng_div_counter`: SIZE-bit up-counter with async active-low reset, synchronous load of `init`, increment enable, and all-ones carry out. The FSM, shadow registers and tick counter live in the top.

## Test plan
- Reset, then D=3, B=4 config + `start` → `prng_en` pulses at E0+4, +8, +12, +16, `done` at E0+17, `tick_cnt`=4, `busy` low at E0+18.
- D=0, B=0, `start`, `stop` after 10 cycles → `prng_en` high all 10 RUN cycles, `tick_cnt`=10, no `done`.
- D=1, B=2, `stop` asserted on the cycle of the 2nd tick → tick seen, `done` never pulses, IDLE next cycle.
- During RUN offer `cfg_valid` with D=7 → `cfg_ready`=0, no capture. Next run still uses the old D.
- Assert `rst` low mid-run at a tick cycle → `prng_en`/`busy`/`tick_cnt` go 0 immediately. After release, `cfg_ready`=1 and `start` with D=0 ticks every cycle.
- Build without `PRNG_RATE_BURST_EN`, B=3 → ticks continue past 3, `tick_cnt` wraps from 255 to 0, `done` stays 0.
